// File: rtl/risc_cpu_pkg.sv
// Shared constants for the risc_cpu compute subsystem: opcodes and instruction field positions.
// MUL_EN adds opcode 13 (MUL); without it the opcode decodes as a NOP.
package risc_cpu_pkg;

  localparam int DEF_DATA_W = 32;

  localparam int OP_HI  = 31;
  localparam int OP_LO  = 26;
  localparam int RD_HI  = 25;
  localparam int RD_LO  = 21;
  localparam int RS_HI  = 20;
  localparam int RS_LO  = 16;
  localparam int RT_HI  = 15;
  localparam int RT_LO  = 11;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;

  typedef logic [5:0] opcode_t;

  localparam opcode_t OP_ADD  = 6'd1;
  localparam opcode_t OP_SUB  = 6'd2;
  localparam opcode_t OP_AND  = 6'd3;
  localparam opcode_t OP_OR   = 6'd4;
  localparam opcode_t OP_XOR  = 6'd5;
  localparam opcode_t OP_ADDI = 6'd6;
  localparam opcode_t OP_LDI  = 6'd7;
  localparam opcode_t OP_LD   = 6'd8;
  localparam opcode_t OP_ST   = 6'd9;
  localparam opcode_t OP_BEQ  = 6'd10;
  localparam opcode_t OP_JMP  = 6'd11;
  localparam opcode_t OP_HALT = 6'd12;
  localparam opcode_t OP_MUL  = 6'd13;

endpackage

// File: rtl/risc_cpu_if.sv
// Operand/result bus between the decode logic (master) and the ALU (slave).
interface risc_cpu_if #(parameter int DATA_W = 32);
  logic [5:0]        op;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [DATA_W-1:0] y;

  modport master (output op, a, b, input y);
  modport slave  (input op, a, b, output y);
endinterface

// File: rtl/risc_cpu_alu.sv
// Combinational ALU for register/immediate arithmetic.
// MUL_EN enables the unsigned low-word multiply; otherwise no multiplier exists.
module risc_cpu_alu
  import risc_cpu_pkg::*;
(
  risc_cpu_if.slave alu
);

  always_comb begin
    alu.y = '0;
    case (alu.op)
      OP_ADD, OP_ADDI: alu.y = alu.a + alu.b;
      OP_SUB:          alu.y = alu.a - alu.b;
      OP_AND:          alu.y = alu.a & alu.b;
      OP_OR:           alu.y = alu.a | alu.b;
      OP_XOR:          alu.y = alu.a ^ alu.b;
`ifdef MUL_EN
      OP_MUL:          alu.y = alu.a * alu.b;
`endif
      default:         alu.y = '0;
    endcase
  end

endmodule

// File: rtl/risc_cpu.sv
// Single-cycle load/store CPU: imem, dmem, register file, pc and decode; ALU in risc_cpu_alu.
// MUL_EN makes opcode 13 a register-writing MUL; otherwise it is a NOP.
module risc_cpu
  import risc_cpu_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int PC_W    = 8,
  parameter int DMEM_AW = 8
) (
  input logic clk,
  input logic reset
);

  logic [31:0]        imem [0:2**PC_W-1];
  logic [DATA_W-1:0]  dmem [0:2**DMEM_AW-1];
  logic [DATA_W-1:0]  rf   [0:31];
  logic [PC_W-1:0]    pc;
  logic               halted;

  logic [DATA_W-1:0] R0,  R1,  R2,  R3,  R4,  R5,  R6,  R7;
  logic [DATA_W-1:0] R8,  R9,  R10, R11, R12, R13, R14, R15;
  logic [DATA_W-1:0] R16, R17, R18, R19, R20, R21, R22, R23;
  logic [DATA_W-1:0] R24, R25, R26, R27, R28, R29, R30, R31;

  assign R0  = '0;     assign R1  = rf[1];  assign R2  = rf[2];  assign R3  = rf[3];
  assign R4  = rf[4];  assign R5  = rf[5];  assign R6  = rf[6];  assign R7  = rf[7];
  assign R8  = rf[8];  assign R9  = rf[9];  assign R10 = rf[10]; assign R11 = rf[11];
  assign R12 = rf[12]; assign R13 = rf[13]; assign R14 = rf[14]; assign R15 = rf[15];
  assign R16 = rf[16]; assign R17 = rf[17]; assign R18 = rf[18]; assign R19 = rf[19];
  assign R20 = rf[20]; assign R21 = rf[21]; assign R22 = rf[22]; assign R23 = rf[23];
  assign R24 = rf[24]; assign R25 = rf[25]; assign R26 = rf[26]; assign R27 = rf[27];
  assign R28 = rf[28]; assign R29 = rf[29]; assign R30 = rf[30]; assign R31 = rf[31];

  logic [31:0]        inst;
  opcode_t            op;
  logic [4:0]         rd, rs, rt;
  logic [DATA_W-1:0]  rd_val, rs_val, rt_val, simm;
  logic [DMEM_AW-1:0] addr;

  assign inst   = imem[pc];
  assign op     = inst[OP_HI:OP_LO];
  assign rd     = inst[RD_HI:RD_LO];
  assign rs     = inst[RS_HI:RS_LO];
  assign rt     = inst[RT_HI:RT_LO];
  assign simm   = {{(DATA_W-16){inst[IMM_HI]}}, inst[IMM_HI:IMM_LO]};
  assign rd_val = (rd == 5'd0) ? '0 : rf[rd];
  assign rs_val = (rs == 5'd0) ? '0 : rf[rs];
  assign rt_val = (rt == 5'd0) ? '0 : rf[rt];
  assign addr   = DMEM_AW'(rs_val + simm);

  risc_cpu_if #(.DATA_W(DATA_W)) alu_bus ();
  risc_cpu_alu u_alu (.alu(alu_bus));

  assign alu_bus.op = op;
  assign alu_bus.a  = rs_val;
  assign alu_bus.b  = (op == OP_ADDI) ? simm : rt_val;

  logic              wr_en, st_en, halt_now;
  logic [DATA_W-1:0] wr_data;
  logic [PC_W-1:0]   pc_next;

  always_comb begin
    wr_en    = 1'b0;
    st_en    = 1'b0;
    halt_now = 1'b0;
    wr_data  = alu_bus.y;
    pc_next  = pc + PC_W'(1);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_ADDI: wr_en = 1'b1;
`ifdef MUL_EN
      OP_MUL: wr_en = 1'b1;
`endif
      OP_LDI: begin
        wr_en   = 1'b1;
        wr_data = simm;
      end
      OP_LD: begin
        wr_en   = 1'b1;
        wr_data = dmem[addr];
      end
      OP_ST:  st_en = 1'b1;
      OP_BEQ: if (rd_val == rs_val) pc_next = pc + PC_W'(1) + simm[PC_W-1:0];
      OP_JMP: pc_next = inst[PC_W-1:0];
      OP_HALT: begin
        halt_now = 1'b1;
        pc_next  = pc;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc     <= '0;
      halted <= 1'b0;
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (!halted) begin
      pc     <= pc_next;
      halted <= halt_now;
      if (wr_en && rd != 5'd0) rf[rd] <= wr_data;
    end
  end

  // dmem survives reset; only a live store in run mode touches it
  always_ff @(posedge clk) begin
    if (reset && !halted && st_en) dmem[addr] <= rd_val;
  end

endmodule

// File: tb/tb_risc_cpu.sv
// Scoreboard bench for risc_cpu: directed programs, expected register/memory dumps queued and checked by a monitor.
module tb_risc_cpu;
  import risc_cpu_pkg::*;

  localparam int K_REG = 0, K_MEM = 1, K_HALT = 2, K_PC = 3, K_ALU = 4;

  typedef struct {
    int          kind;
    int          idx;
    logic [31:0] val;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic dump = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t sbq[$];
  logic [31:0] prog[$];

  risc_cpu dut (.clk(clk), .reset(reset));

  risc_cpu_if #(.DATA_W(32)) u_if ();
  risc_cpu_alu u_alu (.alu(u_if));

  always #5 clk = ~clk;

  function automatic logic [31:0] enc_r(opcode_t op, int rd, int rs, int rt);
    logic [4:0] d, s, t;
    d = rd[4:0]; s = rs[4:0]; t = rt[4:0];
    return {op, d, s, t, 11'b0};
  endfunction

  function automatic logic [31:0] enc_i(opcode_t op, int rd, int rs, logic [15:0] imm);
    logic [4:0] d, s;
    d = rd[4:0]; s = rs[4:0];
    return {op, d, s, imm};
  endfunction

  function automatic logic [31:0] get_reg(int i);
    case (i)
      0:  return dut.R0;   1:  return dut.R1;   2:  return dut.R2;   3:  return dut.R3;
      4:  return dut.R4;   5:  return dut.R5;   6:  return dut.R6;   7:  return dut.R7;
      8:  return dut.R8;   9:  return dut.R9;   10: return dut.R10;  11: return dut.R11;
      12: return dut.R12;  13: return dut.R13;  14: return dut.R14;  15: return dut.R15;
      16: return dut.R16;  17: return dut.R17;  18: return dut.R18;  19: return dut.R19;
      20: return dut.R20;  21: return dut.R21;  22: return dut.R22;  23: return dut.R23;
      24: return dut.R24;  25: return dut.R25;  26: return dut.R26;  27: return dut.R27;
      28: return dut.R28;  29: return dut.R29;  30: return dut.R30;  default: return dut.R31;
    endcase
  endfunction

  // monitor: drains the scoreboard whenever a dump is presented
  always @(negedge clk) begin
    exp_t e;
    logic [31:0] act;
    if (dump) begin
      while (sbq.size() > 0) begin
        e = sbq.pop_front();
        case (e.kind)
          K_REG:   act = get_reg(e.idx);
          K_MEM:   act = dut.dmem[e.idx[7:0]];
          K_HALT:  act = {31'b0, dut.halted};
          K_PC:    act = {24'b0, dut.pc};
          default: act = u_if.y;
        endcase
        checks++;
        if (act !== e.val) begin
          errors++;
          $display("FAIL %s: got %h, expected %h", e.name, act, e.val);
        end
      end
    end
  end

  task automatic expect_val(int kind, int idx, logic [31:0] val, string name);
    exp_t e;
    e.kind = kind; e.idx = idx; e.val = val; e.name = name;
    sbq.push_back(e);
  endtask

  task automatic do_check();
    @(posedge clk);
    dump = 1'b1;
    @(posedge clk);
    dump = 1'b0;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sbq.size());
      sbq.delete();
    end
  endtask

  task automatic start_prog(int cycles);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 256; i++) dut.imem[i] = 32'h0;
    for (int i = 0; i < prog.size(); i++) dut.imem[i] = prog[i];
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (cycles) @(posedge clk);
  endtask

  initial begin
    // ALU program
    prog = {enc_i(OP_LDI, 1, 0, 16'd5), enc_i(OP_LDI, 2, 0, 16'hFFFD),
            enc_r(OP_ADD, 3, 1, 2), enc_r(OP_SUB, 4, 1, 2),
            enc_r(OP_XOR, 5, 1, 2), enc_i(OP_HALT, 0, 0, 16'd0)};
    start_prog(20);
    expect_val(K_REG, 3, 32'd2, "alu_add");
    expect_val(K_REG, 4, 32'd8, "alu_sub");
    expect_val(K_REG, 5, 32'hFFFF_FFF8, "alu_xor");
    expect_val(K_HALT, 0, 32'd1, "alu_halted");
    do_check();
    repeat (20) @(posedge clk);
    expect_val(K_REG, 3, 32'd2, "alu_add_hold");
    expect_val(K_REG, 4, 32'd8, "alu_sub_hold");
    expect_val(K_REG, 5, 32'hFFFF_FFF8, "alu_xor_hold");
    do_check();

    // reset held two edges over a dirty register file
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 32; i++) expect_val(K_REG, i, 32'd0, $sformatf("reset_r%0d", i));
    expect_val(K_PC, 0, 32'd0, "reset_pc");
    expect_val(K_HALT, 0, 32'd0, "reset_halted");
    do_check();

    // R0 hardwired zero
    prog = {enc_i(OP_LDI, 0, 0, 16'd7), enc_i(OP_ADDI, 6, 0, 16'd1), enc_i(OP_HALT, 0, 0, 16'd0)};
    start_prog(10);
    expect_val(K_REG, 0, 32'd0, "r0_zero");
    expect_val(K_REG, 6, 32'd1, "r0_addi");
    do_check();

    // store then load in the next cycle
    prog = {enc_i(OP_LDI, 1, 0, 16'd42), enc_i(OP_ST, 1, 0, 16'd10),
            enc_i(OP_LD, 7, 0, 16'd10), enc_i(OP_HALT, 0, 0, 16'd0)};
    start_prog(10);
    expect_val(K_REG, 7, 32'd42, "mem_ld");
    expect_val(K_MEM, 10, 32'd42, "mem_dmem10");
    do_check();

    // counting loop
    prog = {enc_i(OP_LDI, 1, 0, 16'd0), enc_i(OP_LDI, 2, 0, 16'd5),
            enc_i(OP_ADDI, 1, 1, 16'd1), enc_i(OP_BEQ, 1, 2, 16'd1),
            enc_i(OP_JMP, 0, 0, 16'd2), enc_i(OP_HALT, 0, 0, 16'd0)};
    start_prog(40);
    expect_val(K_REG, 1, 32'd5, "loop_r1");
    expect_val(K_HALT, 0, 32'd1, "loop_halted");
    do_check();

    // reset pulse in the middle of the loop
    start_prog(7);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    expect_val(K_REG, 1, 32'd0, "midrst_r1_clear");
    expect_val(K_REG, 2, 32'd0, "midrst_r2_clear");
    expect_val(K_PC, 0, 32'd0, "midrst_pc");
    do_check();
    @(negedge clk);
    reset = 1'b1;
    repeat (40) @(posedge clk);
    expect_val(K_REG, 1, 32'd5, "midrst_r1_rerun");
    expect_val(K_HALT, 0, 32'd1, "midrst_halted");
    expect_val(K_MEM, 10, 32'd42, "midrst_dmem_kept");
    do_check();

    // pc wrap from 255 to 0 and a taken branch
    prog = {enc_i(OP_ADDI, 9, 9, 16'd1), enc_i(OP_LDI, 10, 0, 16'd2),
            enc_i(OP_BEQ, 9, 10, 16'd1), enc_i(OP_JMP, 0, 0, 16'd255),
            enc_i(OP_HALT, 0, 0, 16'd0)};
    for (int i = prog.size(); i < 255; i++) prog.push_back(32'h0);
    prog.push_back(enc_i(OP_LDI, 8, 0, 16'd9));
    start_prog(20);
    expect_val(K_REG, 8, 32'd9, "wrap_r8");
    expect_val(K_REG, 9, 32'd2, "wrap_r9");
    expect_val(K_HALT, 0, 32'd1, "wrap_halted");
    do_check();

    // opcode 13
    prog = {enc_i(OP_LDI, 1, 0, 16'd6), enc_i(OP_LDI, 2, 0, 16'd7),
            enc_r(OP_MUL, 3, 1, 2), enc_i(OP_HALT, 0, 0, 16'd0)};
    start_prog(10);
`ifdef MUL_EN
    expect_val(K_REG, 3, 32'd42, "mul_r3");
`else
    expect_val(K_REG, 3, 32'd0, "mul_r3");
`endif
    do_check();

    // standalone ALU over the interface: wrap-around cases
    u_if.op = OP_SUB; u_if.a = 32'd0; u_if.b = 32'd1;
    expect_val(K_ALU, 0, 32'hFFFF_FFFF, "alu_if_sub_wrap");
    do_check();
    u_if.op = OP_ADD; u_if.a = 32'hFFFF_FFFF; u_if.b = 32'd1;
    expect_val(K_ALU, 0, 32'd0, "alu_if_add_wrap");
    do_check();
    u_if.op = OP_AND; u_if.a = 32'hF0F0_F0F0; u_if.b = 32'hFF00_FF00;
    expect_val(K_ALU, 0, 32'hF000_F000, "alu_if_and");
    do_check();
    u_if.op = OP_OR;
    expect_val(K_ALU, 0, 32'hFFF0_FFF0, "alu_if_or");
    do_check();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
